atan_share_arbiter: RTL and testbench

//   Shares one Arctan2 core between NUM_REQ requesters, e.g. the Gamma, AtanXY and Theta2 phases of
//   the angle solver, or a second solver instance. Sequence per job: round-robin arbitration,

---
 rtl/atan_share_arbiter.sv | 106 ++++++++++
 tb/tb_atan_share_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/atan_share_arbiter.sv
// Round-robin front end that time-shares one Arctan2 core between NUM_REQ requesters.
// One job at a time: grant, latch operands, run the core, return the angle, flush the core.
module atan_share_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ANGLE_W = 13,
    parameter int TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [64*NUM_REQ-1:0]  arg1_in,
    input  logic [64*NUM_REQ-1:0]  arg2_in,
    output logic [NUM_REQ-1:0]     done,
    output logic [NUM_REQ-1:0]     err,
    output logic [ANGLE_W-1:0]     angle_out,
    output logic                   busy,
    output logic [63:0]            core_arg1,
    output logic [63:0]            core_arg2,
    output logic                   core_enable,
    output logic                   core_reset,
    input  logic [ANGLE_W-1:0]     core_angle,
    input  logic                   core_ready
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD    = 3'd1;
    localparam logic [2:0] RUN     = 3'd2;
    localparam logic [2:0] DELIVER = 3'd3;
    localparam logic [2:0] FLUSH   = 3'd4;

    logic [2:0]    state;
    logic [IW-1:0] rr;
    logic [IW-1:0] win;
    logic [IW-1:0] pick;
    logic [CW-1:0] wd;

    // Scan offsets high to low so the smallest offset from rr is the last writer and wins.
    always_comb begin
        int j;
        j    = 0;
        pick = rr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(rr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (req[IW'(j)]) pick = IW'(j);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr        <= '0;
            win       <= '0;
            wd        <= '0;
            done      <= '0;
            err       <= '0;
            angle_out <= '0;
            core_arg1 <= '0;
            core_arg2 <= '0;
        end else begin
            done <= '0;
            err  <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        win       <= pick;
                        core_arg1 <= arg1_in[64*pick +: 64];
                        core_arg2 <= arg2_in[64*pick +: 64];
                        rr        <= (pick == IW'(NUM_REQ - 1)) ? '0 : pick + IW'(1);
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    wd    <= '0;
                    state <= RUN;
                end
                RUN: begin
                    // A requester that walked away gets nothing back, even if the core just finished.
                    if (!req[win]) begin
                        state <= FLUSH;
                    end else if (core_ready) begin
                        angle_out <= core_angle;
                        done[win] <= 1'b1;
                        state     <= DELIVER;
                    end else if (wd == CW'(TIMEOUT)) begin
                        err[win] <= 1'b1;
                        state    <= FLUSH;
                    end else begin
                        wd <= wd + CW'(1);
                    end
                end
                DELIVER: state <= FLUSH;
                FLUSH:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign core_enable = (state == RUN);
    assign core_reset  = (state == IDLE) || (state == FLUSH);

endmodule

// File: tb/tb_atan_share_arbiter.sv
// Directed bench for atan_share_arbiter: table of jobs against a cycle-counting core model,
// plus hand sequences for reset behaviour.
module tb_atan_share_arbiter;

    localparam int NR = 3;
    localparam int AW = 13;
    localparam int TO = 20;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req;
    logic [64*NR-1:0]  arg1_in, arg2_in;
    logic [NR-1:0]     done, err;
    logic [AW-1:0]     angle_out;
    logic              busy;
    logic [63:0]       core_arg1, core_arg2;
    logic              core_enable, core_reset;
    logic [AW-1:0]     core_angle;
    logic              core_ready;

    atan_share_arbiter #(.NUM_REQ(NR), .ANGLE_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .arg1_in(arg1_in), .arg2_in(arg2_in),
        .done(done), .err(err), .angle_out(angle_out), .busy(busy),
        .core_arg1(core_arg1), .core_arg2(core_arg2), .core_enable(core_enable),
        .core_reset(core_reset), .core_angle(core_angle), .core_ready(core_ready)
    );

    always #5 clk = ~clk;

    // Core model: DataReady on the ready_at-th enabled cycle, counting the first as 0.
    int en_cnt = 0;
    int ready_at = -1;
    always @(posedge clk) en_cnt <= core_enable ? en_cnt + 1 : 0;
    assign core_ready = core_enable && (en_cnt == ready_at);

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pat1(input int i);
        return 64'h3FF0_0000_0000_0000 + 64'(i) * 64'h0000_0001_0001_0001;
    endfunction
    function automatic logic [63:0] pat2(input int i);
        return 64'hC008_0000_0000_0000 + 64'(i) * 64'h0000_0100_0000_0011;
    endfunction

    task automatic set_args();
        for (int i = 0; i < NR; i++) begin
            arg1_in[64*i +: 64] = pat1(i);
            arg2_in[64*i +: 64] = pat2(i);
        end
    endtask

    typedef struct {
        logic [NR-1:0] rq;
        logic [NR-1:0] rq_after;
        int            rdy;
        int            drop_cyc;
        logic [AW-1:0] ang;
        int            win;
        int            exp_done;
        int            exp_err;
        logic [AW-1:0] exp_angle;
        int            exp_idle;
    } vec_t;

    function automatic vec_t mk(input logic [NR-1:0] rq, input logic [NR-1:0] rq_after,
                                input int rdy, input int drop_cyc, input int ang, input int win,
                                input int exp_done, input int exp_err, input int exp_angle,
                                input int exp_idle);
        vec_t v;
        v.rq = rq; v.rq_after = rq_after; v.rdy = rdy; v.drop_cyc = drop_cyc;
        v.ang = AW'(ang); v.win = win; v.exp_done = exp_done; v.exp_err = exp_err;
        v.exp_angle = AW'(exp_angle); v.exp_idle = exp_idle;
        return v;
    endfunction

    // Cycle 0 is the IDLE cycle whose closing edge samples req; cycle k is observed at the k-th negedge.
    task automatic run_job(input string tag, input vec_t v);
        int done_cyc, err_cyc, idle_cyc;
        logic [NR-1:0] done_vec, err_vec;
        logic [63:0] la1, la2;
        logic lrst, len, len2, rst_after, multi, unstable;
        done_cyc = -1; err_cyc = -1; idle_cyc = -1;
        done_vec = '0; err_vec = '0; la1 = '0; la2 = '0;
        lrst = 1'b1; len = 1'b1; len2 = 1'b0; rst_after = 1'b0; multi = 1'b0; unstable = 1'b0;
        req = v.rq; ready_at = v.rdy; core_angle = v.ang;
        for (int k = 1; k <= 60 && idle_cyc < 0; k++) begin
            @(negedge clk);
            if (done != '0) begin done_cyc = k; done_vec = done; end
            if (err != '0)  begin err_cyc = k;  err_vec = err;  end
            if ($countones(done | err) > 1) multi = 1'b1;
            if (k == 1) begin la1 = core_arg1; la2 = core_arg2; lrst = core_reset; len = core_enable; end
            else if (busy && (core_arg1 !== la1 || core_arg2 !== la2)) unstable = 1'b1;
            if (k == 2) begin
                len2 = core_enable;
                arg1_in = ~arg1_in;
                arg2_in = ~arg2_in;
            end
            if (v.drop_cyc > 0 && k == v.drop_cyc + 1) rst_after = core_reset;
            if (v.drop_cyc > 0 && k == v.drop_cyc) req = '0;
            if (done != '0 || err != '0) req = v.rq_after;
            if (!busy) idle_cyc = k;
        end
        set_args();
        chk({tag, " grant arg1"}, la1, pat1(v.win));
        chk({tag, " grant arg2"}, la2, pat2(v.win));
        chk({tag, " load rst/en"}, {62'b0, lrst, len}, 64'b0);
        chk({tag, " run enable"}, {63'b0, len2}, 64'b1);
        chk({tag, " done cycle"}, 64'(done_cyc), 64'(v.exp_done));
        chk({tag, " done vec"}, 64'(done_vec), (v.exp_done >= 0) ? (64'b1 << v.win) : 64'b0);
        chk({tag, " err cycle"}, 64'(err_cyc), 64'(v.exp_err));
        chk({tag, " err vec"}, 64'(err_vec), (v.exp_err >= 0) ? (64'b1 << v.win) : 64'b0);
        chk({tag, " angle_out"}, 64'(angle_out), 64'(v.exp_angle));
        chk({tag, " idle cycle"}, 64'(idle_cyc), 64'(v.exp_idle));
        chk({tag, " one-hot pulses"}, {63'b0, multi}, 64'b0);
        chk({tag, " operands held"}, {63'b0, unstable}, 64'b0);
        if (v.drop_cyc > 0) chk({tag, " core_reset after drop"}, {63'b0, rst_after}, 64'b1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " busy"}, {63'b0, busy}, 64'b0);
        chk({tag, " core_reset"}, {63'b0, core_reset}, 64'b1);
        chk({tag, " core_enable"}, {63'b0, core_enable}, 64'b0);
        chk({tag, " done/err"}, 64'({done, err}), 64'b0);
        chk({tag, " angle_out"}, 64'(angle_out), 64'b0);
        chk({tag, " core_args"}, core_arg1 | core_arg2, 64'b0);
    endtask

    vec_t tbl[10];

    initial begin
        //            rq      after   rdy drop ang    win done err  exp_ang idle
        tbl[0] = mk(3'b111, 3'b111,  3, 0,   100,  0,  6,  -1,  100,    8);
        tbl[1] = mk(3'b111, 3'b111,  3, 0,   200,  1,  6,  -1,  200,    8);
        tbl[2] = mk(3'b111, 3'b111,  3, 0,   300,  2,  6,  -1,  300,    8);
        tbl[3] = mk(3'b111, 3'b000,  3, 0,   400,  0,  6,  -1,  400,    8);
        tbl[4] = mk(3'b001, 3'b000,  5, 0,   804,  0,  8,  -1,  804,   10);
        tbl[5] = mk(3'b100, 3'b000, -1, 0,   555,  2, -1,  23,  804,   24);
        tbl[6] = mk(3'b001, 3'b000, 20, 0, -1608,  0, 23,  -1, -1608,  25);
        tbl[7] = mk(3'b010, 3'b000, 10, 4,   900,  1, -1,  -1, -1608,   6);
        tbl[8] = mk(3'b101, 3'b000,  1, 0,     7,  2,  4,  -1,    7,    6);
        tbl[9] = mk(3'b110, 3'b000,  2, 0,    -1,  1,  5,  -1,   -1,    7);

        reset = 1'b1; req = '0; core_angle = '0; set_args();
        repeat (3) @(negedge clk);
        chk_reset_state("por");
        reset = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 10; t++) run_job($sformatf("job%0d", t), tbl[t]);

        // Reset during RUN while rr points at requester 2; afterwards req=110 must go to 1.
        req = 3'b010; ready_at = -1; core_angle = AW'(77);
        repeat (4) @(negedge clk);
        chk("pre-reset in RUN", {63'b0, core_enable}, 64'b1);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_state("midrun");
        reset = 1'b0; req = '0;
        @(negedge clk);
        run_job("post-reset", mk(3'b110, 3'b000, 3, 0, 42, 1, 6, -1, 42, 8));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
